// File: rtl/axis_pattern_gen_if.sv
// Multi-channel AXI4-Stream bundle: tdata is NUM_CH lanes of DATA_WIDTH bits,
// handshake and framing signals are one bit per channel.
interface axis_pattern_gen_if #(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [NUM_CH*DATA_WIDTH-1:0] tdata;
    logic [NUM_CH-1:0]            tvalid;
    logic [NUM_CH-1:0]            tlast;
    logic [NUM_CH-1:0]            tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_pattern_gen.sv
// Multi-channel AXI4-Stream test-traffic source: per-channel ramp, per-packet ramp,
// constant or Galois-LFSR data with configurable packet length and packet count.
module axis_pattern_gen #(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 24,
    parameter int unsigned CNT_WIDTH  = 16,
    parameter logic [31:0] LFSR_TAPS  = 32'h8020_0003
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [NUM_CH-1:0]           start,
    input  logic [NUM_CH-1:0]           stop,
    input  logic [LEN_WIDTH-1:0]        cfg_pkt_len,
    input  logic [CNT_WIDTH-1:0]        cfg_num_pkts,
    input  logic [1:0]                  cfg_mode,
    input  logic [DATA_WIDTH-1:0]       cfg_seed,
    axis_pattern_gen_if.master          m_axis,
    output logic [NUM_CH-1:0]           busy,
    output logic [NUM_CH-1:0]           done,
    output logic [NUM_CH*CNT_WIDTH-1:0] pkt_cnt
);

    localparam logic [DATA_WIDTH-1:0] Taps = DATA_WIDTH'(LFSR_TAPS);

    typedef enum logic {StIdle, StRun} state_e;

    // Assert asynchronously, release two aclk edges after areset drops.
    logic [1:0] rst_sync_q;
    logic       rst;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) rst_sync_q <= 2'b11;
        else        rst_sync_q <= {rst_sync_q[0], 1'b0};
    end

    assign rst = rst_sync_q[1];

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        state_e                state_q, state_d;
        logic [LEN_WIDTH-1:0]  lenm1_q, lenm1_d, beat_q, beat_d;
        logic [CNT_WIDTH-1:0]  num_q, num_d, cnt_q, cnt_d, cnt_inc;
        logic [1:0]            mode_q, mode_d;
        logic [DATA_WIDTH-1:0] seed_q, seed_d, data_q, data_d, seed_k;
        logic                  stop_pend_q, stop_pend_d, done_q, done_d;
        logic                  last, fire;

        assign seed_k  = cfg_seed + DATA_WIDTH'(k);
        assign last    = (state_q == StRun) && (beat_q == lenm1_q);
        assign fire    = (state_q == StRun) && m_axis.tready[k];
        assign cnt_inc = cnt_q + CNT_WIDTH'(1);

        always_comb begin
            state_d     = state_q;
            lenm1_d     = lenm1_q;
            beat_d      = beat_q;
            num_d       = num_q;
            cnt_d       = cnt_q;
            mode_d      = mode_q;
            seed_d      = seed_q;
            data_d      = data_q;
            stop_pend_d = stop_pend_q;
            done_d      = 1'b0;
            case (state_q)
                StIdle: begin
                    if (start[k]) begin
                        state_d     = StRun;
                        lenm1_d     = (cfg_pkt_len == '0) ? '0 : cfg_pkt_len - LEN_WIDTH'(1);
                        num_d       = cfg_num_pkts;
                        mode_d      = cfg_mode;
                        // An all-zero LFSR state would lock up, so it is nudged to 1.
                        seed_d      = (cfg_mode == 2'b11 && seed_k == '0) ?
                                      DATA_WIDTH'(1) : seed_k;
                        data_d      = seed_d;
                        beat_d      = '0;
                        cnt_d       = '0;
                        stop_pend_d = 1'b0;
                    end
                end
                StRun: begin
                    if (stop[k]) stop_pend_d = 1'b1;
                    if (fire) begin
                        case (mode_q)
                            2'b00:   data_d = data_q + DATA_WIDTH'(1);
                            2'b01:   data_d = last ? seed_q : data_q + DATA_WIDTH'(1);
                            2'b10:   data_d = seed_q;
                            default: data_d = (data_q >> 1) ^ (data_q[0] ? Taps : '0);
                        endcase
                        if (last) begin
                            beat_d = '0;
                            cnt_d  = cnt_inc;
                            if ((num_q != '0 && cnt_inc == num_q) || stop_pend_q || stop[k]) begin
                                state_d     = StIdle;
                                done_d      = 1'b1;
                                stop_pend_d = 1'b0;
                            end
                        end else begin
                            beat_d = beat_q + LEN_WIDTH'(1);
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        always_ff @(posedge aclk or posedge rst) begin
            if (rst) begin
                state_q     <= StIdle;
                lenm1_q     <= '0;
                beat_q      <= '0;
                num_q       <= '0;
                cnt_q       <= '0;
                mode_q      <= '0;
                seed_q      <= '0;
                data_q      <= '0;
                stop_pend_q <= 1'b0;
                done_q      <= 1'b0;
            end else begin
                state_q     <= state_d;
                lenm1_q     <= lenm1_d;
                beat_q      <= beat_d;
                num_q       <= num_d;
                cnt_q       <= cnt_d;
                mode_q      <= mode_d;
                seed_q      <= seed_d;
                data_q      <= data_d;
                stop_pend_q <= stop_pend_d;
                done_q      <= done_d;
            end
        end

        assign m_axis.tdata[k*DATA_WIDTH +: DATA_WIDTH] = data_q;
        assign m_axis.tvalid[k]                          = (state_q == StRun);
        assign m_axis.tlast[k]                           = last;
        assign busy[k]                                   = (state_q == StRun);
        assign done[k]                                   = done_q;
        assign pkt_cnt[k*CNT_WIDTH +: CNT_WIDTH]         = cnt_q;
    end

endmodule
